// File: rtl/usb_dfifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// usb_dfifo_arbiter_if
// Bundles the signals around the data-FIFO SRAM arbiter:
//   - OTG DFIFO port   : core_ce_n, core_wr_n, core_addr, core_wdata, core_rdata
//   - secondary port   : dbg_req_valid/ready/we/addr/wdata, dbg_rsp_valid/data
//   - init control     : init_req, init_done
//   - SRAM pins        : ram_ce_n, ram_we_n, ram_addr, ram_din, ram_dout
//   - USB_DFIFO_ARB_PERF_EN adds conflict_cnt (out) and conflict_clr (in)
// Modport slave is the arbiter side; master is the surrounding system/bench.
// -----------------------------------------------------------------------------
interface usb_dfifo_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 35
);
   logic              core_ce_n;
   logic              core_wr_n;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              dbg_req_valid;
   logic              dbg_req_ready;
   logic              dbg_req_we;
   logic [ADDR_W-1:0] dbg_req_addr;
   logic [DATA_W-1:0] dbg_req_wdata;
   logic              dbg_rsp_valid;
   logic [DATA_W-1:0] dbg_rsp_data;
   logic              init_req;
   logic              init_done;
   logic              ram_ce_n;
   logic              ram_we_n;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;
`ifdef USB_DFIFO_ARB_PERF_EN
   logic [15:0]       conflict_cnt;
   logic              conflict_clr;
`endif

   modport slave (
      input  core_ce_n, core_wr_n, core_addr, core_wdata,
      output core_rdata,
      input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
      output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
      input  init_req,
      output init_done,
      output ram_ce_n, ram_we_n, ram_addr, ram_din,
      input  ram_dout
`ifdef USB_DFIFO_ARB_PERF_EN
      , output conflict_cnt
      , input  conflict_clr
`endif
   );

   modport master (
      output core_ce_n, core_wr_n, core_addr, core_wdata,
      input  core_rdata,
      output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
      input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
      output init_req,
      input  init_done,
      input  ram_ce_n, ram_we_n, ram_addr, ram_din,
      output ram_dout
`ifdef USB_DFIFO_ARB_PERF_EN
      , input  conflict_cnt
      , output conflict_clr
`endif
   );
endinterface

// File: rtl/usb_dfifo_arbiter.sv
// -----------------------------------------------------------------------------
// usb_dfifo_arbiter
// Shares the single-port data-FIFO SRAM (1-cycle read latency) between the OTG
// DFIFO port, which has strict priority and never stalls, and a secondary
// valid/ready requester that only gets idle SRAM cycles. An init sequencer
// zero-fills the whole SRAM after reset (INIT_ON_RESET=1) or on init_req;
// init_done is high only in RUN.
//
// Ports:
//   aclk     clock
//   aresetn  asynchronous active-low reset
//   bus      usb_dfifo_arbiter_if.slave: OTG port, secondary req/rsp port,
//            init_req/init_done, SRAM pins
//
// Optional build macro USB_DFIFO_ARB_PERF_EN: adds a saturating 16-bit count
// of RUN cycles where the secondary requester was blocked by the OTG port,
// cleared by conflict_clr.
// -----------------------------------------------------------------------------
module usb_dfifo_arbiter #(
   parameter int ADDR_W        = 11,
   parameter int DATA_W        = 35,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic               aclk,
   input  logic               aresetn,
   usb_dfifo_arbiter_if.slave bus
);
   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam state_t          RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;
   // init_addr carries one extra bit; the sweep ends on depth-1, not overflow
   localparam logic [ADDR_W:0] LAST_ADDR   = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] ADDR_ONE    = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   init_addr_q, init_addr_d;
   logic              dbg_pend_q, dbg_pend_d;

   logic              ram_ce_n_c;
   logic              ram_we_n_c;
   logic [ADDR_W-1:0] ram_addr_c;
   logic [DATA_W-1:0] ram_din_c;
   logic              dbg_ready_c;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= RESET_STATE;
         init_addr_q <= '0;
         dbg_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         dbg_pend_q  <= dbg_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      ram_ce_n_c  = 1'b1;
      ram_we_n_c  = 1'b1;
      ram_addr_c  = '0;
      ram_din_c   = '0;
      dbg_ready_c = 1'b0;
      case (state_q)
         ST_INIT: begin
            ram_ce_n_c = 1'b0;
            ram_we_n_c = 1'b0;
            ram_addr_c = init_addr_q[ADDR_W-1:0];
            if (bus.init_req) begin
               init_addr_d = '0;
            end else if (init_addr_q == LAST_ADDR) begin
               state_d     = ST_RUN;
               init_addr_d = '0;
            end else begin
               init_addr_d = init_addr_q + ADDR_ONE;
            end
         end
         ST_RUN: begin
            // Combinational from core_ce_n: the OTG port cannot be held off
            dbg_ready_c = bus.core_ce_n;
            if (!bus.core_ce_n) begin
               ram_ce_n_c = 1'b0;
               ram_we_n_c = bus.core_wr_n;
               ram_addr_c = bus.core_addr;
               ram_din_c  = bus.core_wdata;
            end else if (bus.dbg_req_valid) begin
               ram_ce_n_c = 1'b0;
               ram_we_n_c = ~bus.dbg_req_we;
               ram_addr_c = bus.dbg_req_addr;
               ram_din_c  = bus.dbg_req_wdata;
            end
            if (bus.init_req) begin
               state_d     = ST_INIT;
               init_addr_d = '0;
            end
         end
      endcase
      // An accepted read is answered next cycle even if INIT starts meanwhile
      dbg_pend_d = bus.dbg_req_valid & dbg_ready_c & ~bus.dbg_req_we;
   end

   // SRAM strobes are forced inactive for as long as reset is held
   assign bus.ram_ce_n      = ram_ce_n_c | ~aresetn;
   assign bus.ram_we_n      = ram_we_n_c | ~aresetn;
   assign bus.ram_addr      = ram_addr_c;
   assign bus.ram_din       = ram_din_c;
   assign bus.dbg_req_ready = dbg_ready_c;
   assign bus.dbg_rsp_valid = dbg_pend_q;
   assign bus.dbg_rsp_data  = bus.ram_dout;
   assign bus.core_rdata    = bus.ram_dout;
   assign bus.init_done     = (state_q == ST_RUN);

`ifdef USB_DFIFO_ARB_PERF_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (bus.conflict_clr) begin
         conflict_cnt_d = '0;
      end else if ((state_q == ST_RUN) && bus.dbg_req_valid && !bus.core_ce_n &&
                   (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         conflict_cnt_q <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign bus.conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_usb_dfifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_dfifo_arbiter
// Bench for usb_dfifo_arbiter with a behavioural 2048x35 SRAM attached to the
// SRAM pins. Inputs change 1 time unit after the rising edge; outputs are
// sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_usb_dfifo_arbiter;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 35;
   localparam int DEPTH  = 2048;

   localparam logic [DATA_W-1:0] PAT_A = 35'h5_A5A5_A5A5;
   localparam logic [DATA_W-1:0] PAT_B = 35'h1_0000_0001;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   logic fill_en = 1'b0;

   always #5 aclk = ~aclk;

   usb_dfifo_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   usb_dfifo_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .INIT_ON_RESET(1'b1)
   ) dut (
      .aclk   (aclk),
      .aresetn(aresetn),
      .bus    (bus)
   );

   // SRAM model: active-low CE/WE, registered read data
   logic [DATA_W-1:0] sram [DEPTH];
   logic [DATA_W-1:0] sram_dout = '0;

   always @(posedge aclk) begin
      if (fill_en) begin
         for (int i = 0; i < DEPTH; i++) sram[i] <= 35'h3_DEAD_BEEF ^ DATA_W'(i);
      end else if (!bus.ram_ce_n) begin
         if (!bus.ram_we_n) sram[bus.ram_addr] <= bus.ram_din;
         else               sram_dout <= sram[bus.ram_addr];
      end
   end
   assign bus.ram_dout = sram_dout;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_core(input logic ce_n, input logic wr_n,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.core_ce_n  = ce_n;
      bus.core_wr_n  = wr_n;
      bus.core_addr  = a;
      bus.core_wdata = d;
   endtask

   task automatic set_dbg(input logic v, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.dbg_req_valid = v;
      bus.dbg_req_we    = we;
      bus.dbg_req_addr  = a;
      bus.dbg_req_wdata = d;
   endtask

   task automatic idle();
      set_core(1'b1, 1'b1, '0, '0);
      set_dbg(1'b0, 1'b0, '0, '0);
      bus.init_req = 1'b0;
`ifdef USB_DFIFO_ARB_PERF_EN
      bus.conflict_clr = 1'b0;
`endif
   endtask

   // Checks n consecutive INIT cycles starting at address 'start' while the
   // OTG and secondary ports try to write garbage.
   task automatic sweep(input int start, input int n, output int errs);
      errs = 0;
      for (int k = start; k < start + n; k++) begin
         set_core(1'b0, 1'b0, ADDR_W'($urandom), DATA_W'({$urandom, $urandom}));
         set_dbg(1'b1, 1'b1, ADDR_W'($urandom), DATA_W'({$urandom, $urandom}));
         #4;
         if (bus.ram_ce_n !== 1'b0 || bus.ram_we_n !== 1'b0 || bus.ram_addr !== ADDR_W'(k) ||
             bus.ram_din !== '0 || bus.init_done !== 1'b0 || bus.dbg_req_ready !== 1'b0)
            errs++;
         nxt();
      end
      idle();
   endtask

   typedef struct {
      logic              cce, cwr;
      logic [ADDR_W-1:0] caddr;
      logic [DATA_W-1:0] cwd;
      logic              dv, dwe;
      logic [ADDR_W-1:0] daddr;
      logic [DATA_W-1:0] dwd;
      logic              ece, ewe;
      logic [ADDR_W-1:0] eaddr;
      logic [DATA_W-1:0] edin;
      logic              erdy;
      logic              chk_bus;
   } vec_t;

   function automatic vec_t mk(logic cce, logic cwr, logic [ADDR_W-1:0] caddr, logic [DATA_W-1:0] cwd,
                               logic dv, logic dwe, logic [ADDR_W-1:0] daddr, logic [DATA_W-1:0] dwd,
                               logic ece, logic ewe, logic [ADDR_W-1:0] eaddr, logic [DATA_W-1:0] edin,
                               logic erdy, logic chk_bus);
      vec_t v;
      v.cce = cce; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
      v.dv = dv; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
      v.ece = ece; v.ewe = ewe; v.eaddr = eaddr; v.edin = edin;
      v.erdy = erdy; v.chk_bus = chk_bus;
      return v;
   endfunction

   vec_t vt [8];

   // reference model state for the randomized phase
   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                pend, pwe, core_act, cwr;
   logic [ADDR_W-1:0] paddr, caddr;
   logic [DATA_W-1:0] pdata, cwd;
   bit                exp_rsp, exp_core, n_rsp, n_core;
   logic [DATA_W-1:0] exp_rsp_data, exp_core_data, n_rsp_data, n_core_data;
   int                errs, nz;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //                core: ce_n wr_n addr    wdata          dbg: v we addr    wdata          exp: ce we addr    din            rdy chk
      vt[0] = mk(1'b1, 1'b1, 11'h000, 35'h0,         1'b0, 1'b0, 11'h000, 35'h0,      1'b1, 1'b1, 11'h000, 35'h0,       1'b1, 1'b0);
      vt[1] = mk(1'b0, 1'b0, 11'h7FF, PAT_B,         1'b1, 1'b1, 11'h010, 35'h7,      1'b0, 1'b0, 11'h7FF, PAT_B,       1'b0, 1'b1);
      vt[2] = mk(1'b0, 1'b1, 11'h7FF, 35'h0,         1'b1, 1'b0, 11'h020, 35'h0,      1'b0, 1'b1, 11'h7FF, 35'h0,       1'b0, 1'b1);
      vt[3] = mk(1'b1, 1'b1, 11'h000, 35'h0,         1'b1, 1'b1, 11'h123, PAT_A,      1'b0, 1'b0, 11'h123, PAT_A,       1'b1, 1'b1);
      vt[4] = mk(1'b1, 1'b0, 11'h055, 35'h9,         1'b1, 1'b0, 11'h400, 35'h7,      1'b0, 1'b1, 11'h400, 35'h7,       1'b1, 1'b1);
      vt[5] = mk(1'b0, 1'b0, 11'h000, 35'h7_FFFF_FFFF, 1'b0, 1'b1, 11'h111, 35'h1,    1'b0, 1'b0, 11'h000, 35'h7_FFFF_FFFF, 1'b0, 1'b1);
      vt[6] = mk(1'b0, 1'b1, 11'h001, 35'h1234,      1'b1, 1'b1, 11'h002, 35'h5,      1'b0, 1'b1, 11'h001, 35'h1234,    1'b0, 1'b1);
      vt[7] = mk(1'b1, 1'b0, 11'h3FF, 35'h0,         1'b1, 1'b1, 11'h7FF, 35'h0,      1'b0, 1'b0, 11'h7FF, 35'h0,       1'b1, 1'b1);

      idle();
      // ---- reset state, SRAM pre-filled with non-zero garbage ----
      fill_en = 1'b1;
      nxt();
      fill_en = 1'b0;
      #4;
      check("rst_ce_n",      64'(bus.ram_ce_n),      64'(1));
      check("rst_we_n",      64'(bus.ram_we_n),      64'(1));
      check("rst_init_done", 64'(bus.init_done),     64'(0));
      check("rst_rsp_valid", 64'(bus.dbg_rsp_valid), 64'(0));
      nxt();

      // ---- power-on zero fill ----
      aresetn = 1'b1;
      sweep(0, DEPTH, errs);
      check("init_sweep_errs", 64'(errs), 64'(0));
      #4;
      check("init_done_rise", 64'(bus.init_done),     64'(1));
      check("run_ready_idle", 64'(bus.dbg_req_ready), 64'(1));
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (sram[i] !== '0) nz++;
      check("zero_fill_nonzero_words", 64'(nz), 64'(0));
      nxt();

      // ---- table of RUN mux vectors ----
      for (int i = 0; i < 8; i++) begin
         set_core(vt[i].cce, vt[i].cwr, vt[i].caddr, vt[i].cwd);
         set_dbg(vt[i].dv, vt[i].dwe, vt[i].daddr, vt[i].dwd);
         #4;
         if (vt[i].chk_bus)
            check($sformatf("vec%0d_pins", i),
                  {15'b0, bus.ram_ce_n, bus.ram_we_n, bus.ram_addr, bus.ram_din, bus.dbg_req_ready},
                  {15'b0, vt[i].ece, vt[i].ewe, vt[i].eaddr, vt[i].edin, vt[i].erdy});
         else
            check($sformatf("vec%0d_pins", i),
                  {61'b0, bus.ram_ce_n, bus.ram_we_n, bus.dbg_req_ready},
                  {61'b0, vt[i].ece, vt[i].ewe, vt[i].erdy});
         nxt();
      end
      idle();
      nxt();

      // ---- secondary write then read at 0x123 ----
      set_dbg(1'b1, 1'b1, 11'h123, PAT_A);
      #4; check("dw_ready", 64'(bus.dbg_req_ready), 64'(1)); nxt();
      set_dbg(1'b1, 1'b0, 11'h123, 35'h0);
      #4; check("dr_ready", 64'(bus.dbg_req_ready), 64'(1));
      check("dr_no_rsp_yet", 64'(bus.dbg_rsp_valid), 64'(0)); nxt();
      idle();
      #4; check("dr_rsp_valid", 64'(bus.dbg_rsp_valid), 64'(1));
      check("dr_rsp_data", 64'(bus.dbg_rsp_data), 64'(PAT_A)); nxt();
      #4; check("dr_rsp_one_cycle", 64'(bus.dbg_rsp_valid), 64'(0)); nxt();

      // ---- secondary read stalled by 5 OTG cycles ----
      set_dbg(1'b1, 1'b0, 11'h123, 35'h0);
      errs = 0;
      for (int i = 0; i < 5; i++) begin
         set_core(1'b0, 1'b1, ADDR_W'(16 + i), DATA_W'($urandom));
         #4;
         if (bus.dbg_req_ready !== 1'b0 || bus.ram_ce_n !== 1'b0 || bus.ram_we_n !== 1'b1 ||
             bus.ram_addr !== ADDR_W'(16 + i) || bus.dbg_rsp_valid !== 1'b0) errs++;
         nxt();
      end
      check("stall_cycle_errs", 64'(errs), 64'(0));
      set_core(1'b1, 1'b1, '0, '0);
      #4; check("stall_accept_ready", 64'(bus.dbg_req_ready), 64'(1));
      check("stall_accept_addr", 64'(bus.ram_addr), 64'(11'h123)); nxt();
      idle();
      #4; check("stall_rsp_valid", 64'(bus.dbg_rsp_valid), 64'(1));
      check("stall_rsp_data", 64'(bus.dbg_rsp_data), 64'(PAT_A)); nxt();

      // ---- core write 0x7FF, dbg read, core read 0x7FF during dbg response ----
      set_core(1'b0, 1'b0, 11'h7FF, PAT_B); #4; nxt();
      set_core(1'b1, 1'b1, '0, '0); set_dbg(1'b1, 1'b0, 11'h123, 35'h0);
      #4; check("mix_dbg_ready", 64'(bus.dbg_req_ready), 64'(1)); nxt();
      set_dbg(1'b0, 1'b0, '0, '0); set_core(1'b0, 1'b1, 11'h7FF, 35'h0);
      #4; check("mix_rsp_valid", 64'(bus.dbg_rsp_valid), 64'(1));
      check("mix_rsp_data", 64'(bus.dbg_rsp_data), 64'(PAT_A)); nxt();
      idle();
      #4; check("mix_core_rdata", 64'(bus.core_rdata), 64'(PAT_B));
      check("mix_rsp_done", 64'(bus.dbg_rsp_valid), 64'(0)); nxt();

      // ---- init_req together with an accepted dbg read, then restart at 1000 ----
      set_dbg(1'b1, 1'b0, 11'h123, 35'h0); bus.init_req = 1'b1;
      #4; check("ireq_ready", 64'(bus.dbg_req_ready), 64'(1));
      check("ireq_done_still", 64'(bus.init_done), 64'(1)); nxt();
      idle();
      #4; check("ireq_rsp_valid", 64'(bus.dbg_rsp_valid), 64'(1));
      check("ireq_rsp_data", 64'(bus.dbg_rsp_data), 64'(PAT_A));
      check("ireq_addr0", 64'(bus.ram_addr), 64'(0));
      check("ireq_done_low", 64'(bus.init_done), 64'(0)); nxt();
      sweep(1, 999, errs);
      check("partial_sweep_errs", 64'(errs), 64'(0));
      bus.init_req = 1'b1;
      #4; check("abort_addr", 64'(bus.ram_addr), 64'(1000)); nxt();
      bus.init_req = 1'b0;
      sweep(0, DEPTH, errs);
      check("restart_sweep_errs", 64'(errs), 64'(0));
      #4; check("restart_done", 64'(bus.init_done), 64'(1)); nxt();

      // ---- aresetn pulsed mid-INIT ----
      bus.init_req = 1'b1; #4; nxt(); bus.init_req = 1'b0;
      sweep(0, 500, errs);
      check("pre_reset_sweep_errs", 64'(errs), 64'(0));
      aresetn = 1'b0;
      #4; check("midrst_ce_n", 64'(bus.ram_ce_n), 64'(1));
      check("midrst_we_n", 64'(bus.ram_we_n), 64'(1));
      check("midrst_done", 64'(bus.init_done), 64'(0)); nxt();
      aresetn = 1'b1;
      sweep(0, DEPTH, errs);
      check("post_reset_sweep_errs", 64'(errs), 64'(0));
      #4; check("post_reset_done", 64'(bus.init_done), 64'(1)); nxt();

      // ---- randomized traffic against a transaction-level memory model ----
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      pend = 0; exp_rsp = 0; exp_core = 0;
      exp_rsp_data = '0; exp_core_data = '0;
      for (int c = 0; c < 400; c++) begin
         core_act = ($urandom_range(0, 1) == 0);
         cwr      = ($urandom_range(0, 1) == 1);
         caddr    = ADDR_W'($urandom_range(0, 15));
         cwd      = DATA_W'({$urandom, $urandom});
         if (!pend && $urandom_range(0, 9) < 6) begin
            pend  = 1;
            pwe   = ($urandom_range(0, 1) == 1);
            paddr = ADDR_W'($urandom_range(0, 15));
            pdata = DATA_W'({$urandom, $urandom});
         end
         set_core(~core_act, cwr, caddr, cwd);
         set_dbg(pend, pwe, paddr, pdata);
         #4;
         check("rnd_rsp_valid", 64'(bus.dbg_rsp_valid), 64'(exp_rsp));
         if (exp_rsp)  check("rnd_rsp_data", 64'(bus.dbg_rsp_data), 64'(exp_rsp_data));
         if (exp_core) check("rnd_core_rdata", 64'(bus.core_rdata), 64'(exp_core_data));
         n_rsp = 0; n_core = 0; n_rsp_data = '0; n_core_data = '0;
         if (core_act) begin
            check("rnd_pins_core",
                  {15'b0, bus.ram_ce_n, bus.ram_we_n, bus.ram_addr, bus.ram_din, bus.dbg_req_ready},
                  {15'b0, 1'b0, cwr, caddr, cwd, 1'b0});
            if (!cwr) ref_mem[caddr] = cwd;
            else begin n_core = 1; n_core_data = ref_mem[caddr]; end
         end else if (pend) begin
            check("rnd_pins_dbg",
                  {15'b0, bus.ram_ce_n, bus.ram_we_n, bus.ram_addr, bus.ram_din, bus.dbg_req_ready},
                  {15'b0, 1'b0, ~pwe, paddr, pdata, 1'b1});
            if (pwe) ref_mem[paddr] = pdata;
            else begin n_rsp = 1; n_rsp_data = ref_mem[paddr]; end
            pend = 0;
         end else begin
            check("rnd_pins_idle", {61'b0, bus.ram_ce_n, bus.ram_we_n, bus.dbg_req_ready},
                  {61'b0, 1'b1, 1'b1, 1'b1});
         end
         exp_rsp = n_rsp; exp_rsp_data = n_rsp_data;
         exp_core = n_core; exp_core_data = n_core_data;
         nxt();
      end
      idle();
      #4;
      check("rnd_tail_rsp_valid", 64'(bus.dbg_rsp_valid), 64'(exp_rsp));
      if (exp_rsp) check("rnd_tail_rsp_data", 64'(bus.dbg_rsp_data), 64'(exp_rsp_data));
      nxt();

`ifdef USB_DFIFO_ARB_PERF_EN
      // ---- conflict counter ----
      bus.conflict_clr = 1'b1; #4; nxt();
      bus.conflict_clr = 1'b0;
      #4; check("perf_cleared", 64'(bus.conflict_cnt), 64'(0)); nxt();
      set_core(1'b0, 1'b1, 11'h001, '0); set_dbg(1'b1, 1'b0, 11'h005, '0);
      repeat (3) nxt();
      idle();
      #4; check("perf_three", 64'(bus.conflict_cnt), 64'(3)); nxt();
      set_core(1'b0, 1'b1, 11'h001, '0); set_dbg(1'b1, 1'b0, 11'h005, '0);
      repeat (65600) nxt();
      idle();
      #4; check("perf_saturated", 64'(bus.conflict_cnt), 64'(16'hFFFF)); nxt();
      set_core(1'b0, 1'b1, 11'h001, '0); set_dbg(1'b1, 1'b0, 11'h005, '0);
      bus.conflict_clr = 1'b1; #4; nxt();
      idle();
      #4; check("perf_clr_priority", 64'(bus.conflict_cnt), 64'(0)); nxt();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
